// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-ported unified memory between the
// instruction fetch path and the load/store (MEM stage) path.
// One transaction in flight at a time. Data has priority over fetch, with a
// streak counter that hands the memory to fetch after FETCH_STARVE_LIMIT
// consecutive data grants while fetch was waiting. Fetch responses made stale
// by a late-branch redirect (fetch_kill) are dropped.
module imem_dmem_arbiter #(
  parameter int FETCH_STARVE_LIMIT = 4,
  parameter int STREAK_W           = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch side
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_kill,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic        fetch_stall,
  // load/store side
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(FETCH_STARVE_LIMIT);

  state_t              state;
  owner_t              owner;
  logic                killed;
  logic [STREAK_W-1:0] streak;

  logic                pulse_busy;
  logic                fetch_cand;
  logic                data_cand;
  logic                grant_fetch;
  logic                grant_data;
  logic                fetch_starved;

  // Saturating increment of the data-streak counter; never exceeds the limit.
  function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] s);
    if (s >= STREAK_LIMIT) begin
      return STREAK_LIMIT;
    end
    return s + 1'b1;
  endfunction

  // Stalls: a requester holds until its completion pulse is seen.
  assign fetch_stall = fetch_req & ~fetch_valid;
  assign data_stall  = data_req & ~data_done;

  // Grant candidates. While either completion pulse is high, the requester that
  // just finished still shows its old req, so nobody is granted that cycle; the
  // other requester is picked up one cycle later together with any new request.
  // A fetch is never granted on an edge where fetch_kill is high.
  always_comb begin
    pulse_busy    = fetch_valid | data_done;
    fetch_cand    = fetch_req & ~fetch_kill & ~pulse_busy;
    data_cand     = data_req & ~pulse_busy;
    fetch_starved = (streak == STREAK_LIMIT);
    grant_fetch   = 1'b0;
    grant_data    = 1'b0;
    if (state == IDLE) begin
      grant_fetch = fetch_cand & (~data_cand | fetch_starved);
      grant_data  = data_cand & ~grant_fetch;
    end
  end

  // Arbitration FSM with registered memory-side and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_FETCH;
      killed      <= 1'b0;
      streak      <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'h0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      fetch_valid <= 1'b0;
      fetch_inst  <= 32'h0;
      data_done   <= 1'b0;
      data_rdata  <= 32'h0;
    end else begin
      fetch_valid <= 1'b0;
      data_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fetch) begin
            owner     <= OWN_FETCH;
            killed    <= 1'b0;
            streak    <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= fetch_addr;
            mem_wdata <= 32'h0;
            state     <= REQ;
          end else if (grant_data) begin
            owner     <= OWN_DATA;
            killed    <= 1'b0;
            // Only grants that actually made fetch wait count toward starvation.
            streak    <= fetch_req ? streak_sat_inc(streak) : '0;
            mem_req   <= 1'b1;
            mem_we    <= data_we;
            mem_be    <= data_be;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            state     <= REQ;
          end
        end

        REQ: begin
          if ((owner == OWN_FETCH) && fetch_kill) begin
            killed <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            state  <= IDLE;
            killed <= 1'b0;
            if (owner == OWN_DATA) begin
              data_done <= 1'b1;
              if (!mem_we) begin
                data_rdata <= mem_rdata;
              end
            end else if (!killed && !fetch_kill) begin
              fetch_valid <= 1'b1;
              fetch_inst  <= mem_rdata;
            end
          end else if ((owner == OWN_FETCH) && fetch_kill) begin
            killed <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed testbench for imem_dmem_arbiter: a small memory model with
// programmable ack/response latency, fetch and data requester tasks, and
// hand-computed expectations.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_kill;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_stall;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  imem_dmem_arbiter #(
    .FETCH_STARVE_LIMIT(4),
    .STREAK_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_kill(fetch_kill),
    .fetch_valid(fetch_valid),
    .fetch_inst(fetch_inst),
    .fetch_stall(fetch_stall),
    .data_req(data_req),
    .data_we(data_we),
    .data_be(data_be),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_done(data_done),
    .data_rdata(data_rdata),
    .data_stall(data_stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_be(mem_be),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by reads.
  function automatic logic [31:0] lookup(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h2402_0005;
      32'h1000_0010: return 32'h1122_3344;
      32'h0040_0080: return 32'hDEAD_BEEF;
      32'h0040_0100: return 32'h8C08_0004;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Memory model: acks ack_lat cycles after seeing mem_req, responds rv_lat
  // cycles after the ack; every accepted request is logged.
  int ack_lat = 0;
  int rv_lat  = 2;
  int m_phase = 0;
  int m_cnt   = 0;
  logic [31:0] g_addr[$];
  logic        g_we[$];
  logic [3:0]  g_be[$];
  logic [31:0] g_wd[$];
  logic [2:0]  g_streak[$];

  initial begin
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        m_phase = 0;
        m_cnt   = 0;
      end else if (m_phase == 0) begin
        if (mem_req) begin
          if (m_cnt >= ack_lat) begin
            mem_ack = 1'b1;
            g_addr.push_back(mem_addr);
            g_we.push_back(mem_we);
            g_be.push_back(mem_be);
            g_wd.push_back(mem_wdata);
            g_streak.push_back(dut.streak);
            m_phase = 1;
            m_cnt   = 0;
          end else begin
            m_cnt++;
          end
        end
      end else begin
        m_cnt++;
        if (m_cnt >= rv_lat) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_we ? 32'hBAD0_BAD0 : lookup(mem_addr);
          m_phase    = 0;
          m_cnt      = 0;
        end
      end
    end
  end

  // Count fetch_valid pulses.
  int fv_cnt = 0;
  always @(negedge clk) begin
    if (fetch_valid) fv_cnt++;
  end

  task automatic do_fetch(input logic [31:0] addr, input bit keep,
                          output logic [31:0] inst, output bit ok, output bit stall_ok);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    ok       = 1'b0;
    stall_ok = 1'b1;
    inst     = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fetch_valid) begin
        ok   = 1'b1;
        inst = fetch_inst;
        if (fetch_stall !== 1'b0) stall_ok = 1'b0;
        break;
      end else if (fetch_stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    if (!keep) fetch_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input bit keep,
                         output logic [31:0] rd, output bit ok);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wd;
    ok = 1'b0;
    rd = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_done) begin
        ok = 1'b1;
        rd = data_rdata;
        break;
      end
    end
    if (!keep) data_req = 1'b0;
  endtask

  task automatic clear_log();
    g_addr.delete();
    g_we.delete();
    g_be.delete();
    g_wd.delete();
    g_streak.delete();
  endtask

  logic [31:0] inst, rd;
  bit          okf, okd, sok, okx, ok_all, seen;
  int          fv0;
  logic [5:0]  kinds;
  logic [2:0]  exp_streak[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    fetch_kill = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_req",     mem_req, 0);
    chk("rst_mem_we",      mem_we, 0);
    chk("rst_mem_be",      mem_be, 0);
    chk("rst_mem_addr",    mem_addr, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_data_done",   data_done, 0);
    chk("rst_fetch_inst",  fetch_inst, 0);
    chk("rst_data_rdata",  data_rdata, 0);
    chk("rst_killed",      dut.killed, 0);
    chk("rst_streak",      dut.streak, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone fetch
    clear_log();
    ack_lat = 0; rv_lat = 2;
    fv0 = fv_cnt;
    do_fetch(32'h0040_0000, 1'b0, inst, okf, sok);
    chk("lone_done",  okf, 1);
    chk("lone_inst",  inst, 32'h2402_0005);
    chk("lone_stall", sok, 1);
    chk("lone_be",    g_be[0], 4'hF);
    chk("lone_we",    g_we[0], 0);
    chk("lone_addr",  g_addr[0], 32'h0040_0000);
    repeat (3) @(negedge clk);
    chk("lone_pulses", fv_cnt - fv0, 1);

    // Contention: data first, then fetch with streak reset
    clear_log();
    fork
      do_data(1'b0, 4'hF, 32'h1000_0010, 32'h0, 1'b0, rd, okd);
      do_fetch(32'h0040_0000, 1'b0, inst, okf, sok);
    join
    chk("cont_data_done",  okd, 1);
    chk("cont_fetch_done", okf, 1);
    chk("cont_rdata",      rd, 32'h1122_3344);
    chk("cont_inst",       inst, 32'h2402_0005);
    chk("cont_first",      g_addr[0], 32'h1000_0010);
    chk("cont_second",     g_addr[1], 32'h0040_0000);
    chk("cont_streak0",    g_streak[0], 1);
    chk("cont_streak1",    g_streak[1], 0);
    repeat (2) @(negedge clk);

    // Starvation: six back-to-back stores with fetch held
    clear_log();
    ok_all = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          do_data(1'b1, 4'hF, 32'h1000_0100 + 32'(4 * i), 32'(i), (i < 5), rd, okx);
          ok_all = ok_all & okx;
        end
      end
      begin
        do_fetch(32'h0040_0010, 1'b1, inst, okf, sok);
        do_fetch(32'h0040_0014, 1'b0, inst, okd, sok);
      end
    join
    chk("starve_data_done",  ok_all, 1);
    chk("starve_fetch_done", okf & okd, 1);
    for (int i = 0; i < 6; i++) kinds[i] = (g_addr[i][31:28] == 4'h1);
    chk("starve_order", kinds, 6'b10_1111);
    exp_streak = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    for (int i = 0; i < 6; i++) chk($sformatf("starve_streak%0d", i), g_streak[i], exp_streak[i]);
    repeat (2) @(negedge clk);

    // Kill while the fetch is waiting for its response
    clear_log();
    ack_lat = 0; rv_lat = 3;
    fv0  = fv_cnt;
    seen = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0080;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (g_addr.size() > 0) begin seen = 1'b1; break; end
    end
    chk("killw_granted", seen, 1);
    @(negedge clk);
    fetch_kill = 1'b1;
    fetch_addr = 32'h0040_0100;
    @(negedge clk);
    fetch_kill = 1'b0;
    chk("killw_killed", dut.killed, 1);
    okf = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fetch_valid) begin okf = 1'b1; inst = fetch_inst; break; end
    end
    fetch_req = 1'b0;
    chk("killw_valid",   okf, 1);
    chk("killw_inst",    inst, 32'h8C08_0004);
    chk("killw_regrant", g_addr[1], 32'h0040_0100);
    repeat (2) @(negedge clk);
    chk("killw_pulses", fv_cnt - fv0, 1);

    // Kill coinciding with the response cycle
    rv_lat = 2;
    fv0  = fv_cnt;
    seen = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0200;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (mem_rvalid) begin fetch_kill = 1'b1; seen = 1'b1; break; end
    end
    chk("killr_rvalid", seen, 1);
    @(negedge clk);
    fetch_kill = 1'b0;
    fetch_req  = 1'b0;
    chk("killr_no_valid", fetch_valid, 0);
    chk("killr_killed",   dut.killed, 0);
    repeat (3) @(negedge clk);
    chk("killr_pulses", fv_cnt - fv0, 0);
    chk("killr_idle_req", mem_req, 0);

    // Reset in the middle of a request, then a store
    ack_lat = 5;
    seen = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0300;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    chk("rstm_in_req", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_req_async", mem_req, 0);
    fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    ack_lat = 0;
    clear_log();
    do_data(1'b1, 4'b0011, 32'h1000_0040, 32'h0000_ABCD, 1'b0, rd, okd);
    chk("rstm_store_done", okd, 1);
    chk("rstm_grants",     g_addr.size(), 1);
    chk("rstm_be",         g_be[0], 4'b0011);
    chk("rstm_we",         g_we[0], 1);
    chk("rstm_wdata",      g_wd[0], 32'h0000_ABCD);
    chk("rstm_rdata_kept", rd, 32'h0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares a single-ported unified memory between the instruction fetch path and the load/store path of the pipeline.
- Fetch requests come from the PC/prediction unit's npc. Data requests come from the MEM stage.
- The block generates fetch_stall and data_stall and discards fetch responses made stale by a late-branch redirect.
- It holds at most one transaction in flight and prefers data over fetch, with a starvation guard for fetch.

Parameters:
- FETCH_STARVE_LIMIT, 4: maximum number of consecutive data grants while fetch is pending; after that many, fetch wins the next arbitration.
- STREAK_W, 3: width of the data-streak counter; must satisfy 2^STREAK_W > FETCH_STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_req  in  1  fetch wants the instruction at fetch_addr
- fetch_addr  in  32  word-aligned fetch address (npc)
- fetch_kill  in  1  one-cycle pulse; the in-flight or pending fetch is stale (br_late)
- fetch_valid  out  1  one-cycle pulse; fetch_inst is valid
- fetch_inst  out  32  returned instruction word
- fetch_stall  out  1  fetch must hold its address
- data_req  in  1  load/store request
- data_we  in  1  1 = store
- data_be  in  4  byte enables
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_done  out  1  one-cycle pulse; load data or store completion
- data_rdata  out  32  load data
- data_stall  out  1  MEM stage must hold its request
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_be  out  4  byte enables (4'hF for fetch)
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response or write completion, at least 1 cycle after the ack cycle
- mem_rdata  in  32  read data

Behaviour:
- **States:** IDLE, REQ, WAIT. Owner register: FETCH or DATA. Flag killed.
- **Reset (rst_n=0, async):**
  - State = IDLE; killed = 0; streak = 0.
  - mem_req, mem_we, fetch_valid, data_done = 0.
  - mem_be, mem_addr, mem_wdata, fetch_inst, data_rdata = 0.
  - Reset mid-transaction abandons it; the memory model is reset alongside.
- **IDLE arbitration:**
  - Only data_req → owner DATA.
  - Only fetch_req → owner FETCH.
  - Both requesting: DATA wins, unless streak == FETCH_STARVE_LIMIT, in which case FETCH wins.
  - On a grant, latch the request into the mem_* registers, set mem_req = 1, and go to REQ (1-cycle request latency).
  - A fetch grant takes the clock edge on which fetch_kill is low. If fetch_kill = 1 in that cycle, the fetch is not granted; data is granted instead if requesting.
- **Streak counter:**
  - DATA grant while fetch_req = 1: streak increments, saturating at the limit.
  - FETCH grant, or DATA grant with fetch_req = 0: streak resets to 0.
- **REQ:**
  - mem_* held stable until mem_ack.
  - On mem_ack: mem_req = 0, go to WAIT.
  - Requests are never withdrawn.
- **WAIT:** on mem_rvalid, go to IDLE. In the same cycle register the result (outputs appear 1 cycle after mem_rvalid):
  - owner DATA: data_done = 1; data_rdata = mem_rdata on loads; data_rdata unchanged on stores.
  - owner FETCH, killed = 0 and fetch_kill = 0: fetch_valid = 1; fetch_inst = mem_rdata.
  - owner FETCH, killed, or fetch_kill high in that cycle: response discarded; killed cleared.
- **Kill timing:**
  - fetch_kill while owner = FETCH in REQ or WAIT sets killed.
  - fetch_kill in IDLE, or with owner = DATA, has no effect.
- **Back-to-back:** arbitration happens in IDLE only. Minimum turnaround: mem_rvalid cycle → IDLE, next grant 1 cycle later.
- **Stalls (combinational):**
  - fetch_stall = fetch_req & ~fetch_valid.
  - data_stall = data_req & ~data_done.
- **Requester rules:**
  - A requester holds req, address and data stable until it sees valid/done.
  - It drops req in the cycle after valid/done unless issuing a new request.
  - The arbiter must not regrant a requester in the same cycle its valid/done is high. Its registered grant logic uses the held req only after valid/done is deasserted.

Test Plan:
- **Lone fetch:** fetch_req = 1, fetch_addr = 0x0040_0000; memory acks immediately, rvalid 2 cycles later with 0x2402_0005 → mem_be = 4'hF, mem_we = 0; fetch_valid pulses once with fetch_inst = 0x2402_0005; fetch_stall is low only in that cycle.
- **Contention:** fetch_req and data_req (load, 0x1000_0010) both high in IDLE with streak = 0 → data granted first; data_done with data_rdata; fetch granted next with streak reset.
- **Starvation:** fetch_req held high; 6 back-to-back data stores → grants are D,D,D,D,F,D (limit 4); streak returns to 0 after the fetch grant.
- **Kill in WAIT:** fetch in WAIT, fetch_kill pulses, response 0xDEAD_BEEF arrives → no fetch_valid; the next fetch to 0x0040_0100 returns normally.
- **Kill in rvalid cycle:** fetch_kill coincides with mem_rvalid for a fetch → response discarded; killed ends at 0.
- **Reset mid-operation:** rst_n low while in REQ with mem_req = 1 → mem_req drops asynchronously; after release, state = IDLE and a store (be = 4'b0011, wdata = 0x0000_ABCD) completes with data_done after rvalid.
